// File: rtl/dds_wave_source_if.sv
// Configuration channel for the DDS sample source: one word carries wave, frequency, gain and offset.
// A word transfers on any rising clk100 edge where cfg_valid and cfg_ready are both high; the master holds the fields stable while cfg_valid is high.
interface dds_wave_source_if #(
  parameter int PHASE_W = 32
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [1:0]         cfg_wave;
  logic [PHASE_W-1:0] cfg_freq;
  logic [15:0]        cfg_amp;
  logic [15:0]        cfg_offset;

  modport master (
    output cfg_valid, cfg_wave, cfg_freq, cfg_amp, cfg_offset,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_wave, cfg_freq, cfg_amp, cfg_offset,
    output cfg_ready
  );
endinterface

// File: rtl/dds_wave_source.sv
// DDS sample source for one DAC channel: phase accumulator, waveform generation, gain and offset.
// Three-stage pipeline, one sample per sample_en; configuration is shadowed and applied at phase wrap.
module dds_wave_source #(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 8
) (
  input  logic                clk100,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic                sync_restart,
  dds_wave_source_if.slave    cfg,
  output logic signed [15:0]  sample_out,
  output logic                sample_valid,
  output logic                phase_wrap
);
  localparam int N = 1 << LUT_AW;

  // Quarter-wave table evaluated at elaboration time with a Taylor series.
  function automatic logic [15:0] sine_entry(input int i);
    real x, term, acc;
    x    = 1.5707963267948966 * real'(i) / real'(N);
    term = x;
    acc  = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    return 16'($rtoi(32767.0 * acc + 0.5));
  endfunction

  logic [15:0] lut_rom [N];
  for (genvar gi = 0; gi < N; gi++) begin : g_lut
    localparam logic [15:0] ENTRY = sine_entry(gi);
    assign lut_rom[gi] = ENTRY;
  end

  logic [PHASE_W-1:0] phase, act_freq, sh_freq;
  logic [1:0]         act_wave, sh_wave;
  logic [15:0]        act_amp, act_off, sh_amp, sh_off;
  logic               pending;

  logic               fire, carry, apply, accept;
  logic [PHASE_W:0]   phase_sum;

  assign fire      = sample_en & ~sync_restart;
  assign phase_sum = {1'b0, phase} + {1'b0, act_freq};
  assign carry     = phase_sum[PHASE_W];
  assign apply     = pending & (sync_restart | (fire & (carry | (act_freq == '0))));
  assign accept    = cfg.cfg_valid & ~pending;
  assign cfg.cfg_ready = ~pending;

  // accept needs pending==0 and apply needs pending==1, so they never coincide.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      sh_wave  <= '0;
      sh_freq  <= '0;
      sh_amp   <= '0;
      sh_off   <= '0;
      act_wave <= '0;
      act_freq <= '0;
      act_amp  <= '0;
      act_off  <= '0;
    end else begin
      if (accept) begin
        pending <= 1'b1;
        sh_wave <= cfg.cfg_wave;
        sh_freq <= cfg.cfg_freq;
        sh_amp  <= cfg.cfg_amp;
        sh_off  <= cfg.cfg_offset;
      end else if (apply) begin
        pending <= 1'b0;
      end
      if (apply) begin
        act_wave <= sh_wave;
        act_freq <= sh_freq;
        act_amp  <= sh_amp;
        act_off  <= sh_off;
      end
    end
  end

  // Waveform shapes derived from the pre-increment phase.
  logic [15:0]        u, saw, tri_v;
  logic [1:0]         quad;
  logic [LUT_AW-1:0]  lut_a, lut_a_neg, lut_addr;
  logic signed [15:0] shape;

  assign u         = phase[PHASE_W-1 -: 16];
  assign quad      = phase[PHASE_W-1 -: 2];
  assign lut_a     = phase[PHASE_W-3 -: LUT_AW];
  assign lut_a_neg = '0 - lut_a;
  assign lut_addr  = quad[0] ? lut_a_neg : lut_a;

  always_comb begin
    saw   = {~u[15], u[14:0]};
    tri_v = u[15] ? ~u : u;
    shape = 16'sh0000;
    case (act_wave)
      2'd1:    shape = phase[PHASE_W-1] ? 16'sh8001 : 16'sh7FFF;
      2'd2:    shape = (saw == 16'h8000) ? 16'sh8001 : saw;
      2'd3:    shape = {tri_v[14:0], 1'b0} - 16'sh7FFF;
      default: shape = 16'sh0000;
    endcase
  end

  // S1: phase update plus registered shape, LUT read and per-sample settings.
  logic               s1_valid, s1_a_zero;
  logic [1:0]         s1_wave, s1_q;
  logic [15:0]        s1_amp, s1_off, s1_lut;
  logic signed [15:0] s1_shape;

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= '0;
      phase_wrap <= 1'b0;
      s1_valid   <= 1'b0;
      s1_wave    <= '0;
      s1_q       <= '0;
      s1_a_zero  <= 1'b0;
      s1_amp     <= '0;
      s1_off     <= '0;
      s1_lut     <= '0;
      s1_shape   <= '0;
    end else begin
      phase_wrap <= fire & carry;
      s1_valid   <= fire;
      if (sync_restart) begin
        phase <= '0;
      end else if (fire) begin
        phase <= phase_sum[PHASE_W-1:0];
      end
      if (fire) begin
        s1_wave   <= act_wave;
        s1_q      <= quad;
        s1_a_zero <= (lut_a == '0);
        s1_amp    <= act_amp;
        s1_off    <= act_off;
        s1_lut    <= lut_rom[lut_addr];
        s1_shape  <= shape;
      end
    end
  end

  logic signed [15:0] mag, raw;
  logic signed [31:0] prod;

  always_comb begin
    mag = (s1_q[0] && s1_a_zero) ? 16'sh7FFF : s1_lut;
    raw = s1_shape;
    if (s1_wave == 2'd0) begin
      raw = s1_q[1] ? -mag : mag;
    end
  end

  assign prod = raw * $signed({1'b0, s1_amp});

  // S2: gain with floor shift; S3: offset add with saturation.
  logic               s2_valid;
  logic signed [15:0] s2_prod;
  logic [15:0]        s2_off;
  logic signed [16:0] sum;
  logic signed [15:0] sat;

  assign sum = {s2_prod[15], s2_prod} + {s2_off[15], s2_off};

  always_comb begin
    sat = sum[15:0];
    if (sum[16] != sum[15]) begin
      sat = sum[16] ? 16'sh8000 : 16'sh7FFF;
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid     <= 1'b0;
      s2_prod      <= '0;
      s2_off       <= '0;
      sample_valid <= 1'b0;
      sample_out   <= '0;
    end else begin
      s2_valid     <= s1_valid;
      sample_valid <= s2_valid;
      if (s1_valid) begin
        s2_prod <= 16'(prod >>> 16);
        s2_off  <= s1_off;
      end
      if (s2_valid) begin
        sample_out <= sat;
      end
    end
  end
endmodule
